input_dev: RTL and testbench

- Memory-mapped input peripheral on the CPU/bridge bus; the read-side counterpart of the output device.
- An external producer pushes 32-bit words through a valid/ready handshake into a small FIFO. The CPU reads them through word-addressed registers (addr[3:2]).
- Provides status, control, and a level interrupt request to the CPU.

---
 rtl/dev_pkg.sv | 45 ++++
 rtl/sync_fifo.sv | 78 +++++++
 rtl/input_dev.sv | 115 +++++++++++
 tb/tb_input_dev.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dev_pkg.sv
// Shared register map for the memory-mapped input device: bus addresses,
// STATUS/CTRL bit positions and the STATUS word packer.
package dev_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_CTRL   = 2'b10;
    localparam logic [1:0] ADDR_RSVD   = 2'b11;

    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_IRQ    = 3;
    localparam int ST_CNT_LO = 8;
    localparam int ST_CNT_HI = 15;

    localparam int CT_IRQEN  = 0;
    localparam int CT_FLUSH  = 1;
    localparam int CT_OVFCLR = 2;

    // Field order mirrors the CTRL bit positions so din[2:0] maps straight in.
    typedef struct packed {
        logic ovf_clr;
        logic flush;
        logic irq_en;
    } ctrl_cmd_t;

    function automatic logic [31:0] status_word(
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic       irq,
        input logic [7:0] cnt
    );
        logic [31:0] w;
        w                      = '0;
        w[ST_EMPTY]            = empty;
        w[ST_FULL]             = full;
        w[ST_OVF]              = ovf;
        w[ST_IRQ]              = irq;
        w[ST_CNT_HI:ST_CNT_LO] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and synchronous flush.
// Push is refused while full; flush overrides push and pop in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[head_q];

    assign push_en = push & ~full & ~flush;
    assign pop_en  = pop & ~empty & ~flush;

    // Pointers are exactly log2(DEPTH) bits, so wrap is free modulo DEPTH.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_en) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop_en) begin
                head_d = head_q + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            mem_q[tail_q] <= din;
        end
    end

endmodule

// File: rtl/input_dev.sv
// CPU-readable input peripheral: producer words queue in a FIFO, popped by DATA reads.
// Zero-latency read data; ext_ready drops when full, during a flush write, or in reset.
module input_dev
    import dev_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             ext_valid,
    input  logic [WIDTH-1:0] ext_data,
    output logic             ext_ready,
    output logic             irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic             ovf_q, ovf_d;
    logic             irq_en_q, irq_en_d;

    logic [WIDTH-1:0] fifo_head;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       cnt8;

    logic             rd_data;
    logic             wr_ctrl;
    logic             flush_cycle;
    logic             ovf_clr;
    logic             push;
    logic             pop;
    ctrl_cmd_t        cmd;
    logic             unused_din;

    assign cmd         = din[2:0];
    assign unused_din  = ^din[WIDTH-1:3];

    assign rd_data     = en & ~we & (addr == ADDR_DATA);
    assign wr_ctrl     = en & we & (addr == ADDR_CTRL);
    assign flush_cycle = wr_ctrl & cmd.flush;
    assign ovf_clr     = wr_ctrl & cmd.ovf_clr;

    assign ext_ready   = ~fifo_full & ~flush_cycle & ~rst;
    assign push        = ext_valid & ext_ready;
    assign pop         = rd_data & ~fifo_empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush_cycle),
        .din   (ext_data),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A producer still offering a word while full is an overflow; a same-cycle clear wins.
    always_comb begin
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        if (ext_valid && fifo_full) begin
            ovf_d = 1'b1;
        end
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_ctrl) begin
            irq_en_d = cmd.irq_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
        end
    end

    assign irq  = irq_en_q & ~fifo_empty;
    assign cnt8 = 8'(fifo_count);

    always_comb begin
        dout = '0;
        case (addr)
            ADDR_DATA: begin
                if (!fifo_empty) begin
                    dout = fifo_head;
                end
            end
            ADDR_STATUS: dout = status_word(fifo_empty, fifo_full, ovf_q, irq, cnt8);
            ADDR_CTRL:   dout[CT_IRQEN] = irq_en_q;
            default:     dout = '0;
        endcase
    end

endmodule

// File: tb/tb_input_dev.sv
// Vector table plus scoreboard bench for input_dev (DEPTH=4).
module tb_input_dev;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        ext_valid;
    logic [31:0] ext_data;
    logic        ext_ready;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] sb [$];

    typedef struct {
        logic        en;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic        ev;
        logic [31:0] ed;
        logic [2:0]  chk;
        logic [31:0] exp_dout;
        logic        exp_rdy;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [$];

    always #5 clk = ~clk;

    input_dev #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .we        (we),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .ext_valid (ext_valid),
        .ext_data  (ext_data),
        .ext_ready (ext_ready),
        .irq       (irq)
    );

    function automatic vec_t mk(input logic e, input logic w, input logic [1:0] a,
                                input logic [31:0] d, input logic v, input logic [31:0] x,
                                input logic [2:0] c, input logic [31:0] ed,
                                input logic er, input logic ei);
        vec_t r;
        r.en = e; r.we = w; r.addr = a; r.din = d; r.ev = v; r.ed = x;
        r.chk = c; r.exp_dout = ed; r.exp_rdy = er; r.exp_irq = ei;
        return r;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got %08h want %08h", nm, idx, act, exp);
        end
    endtask

    // One bus cycle: drive, check at negedge, update the model, advance past the edge.
    task automatic cyc(input vec_t v, input int idx);
        logic        full_b;
        logic        flush_b;
        logic [31:0] e;
        en = v.en; we = v.we; addr = v.addr; din = v.din;
        ext_valid = v.ev; ext_data = v.ed;
        @(negedge clk);
        if (v.chk[0]) check("dout", idx, dout, v.exp_dout);
        if (v.chk[1]) check("ext_ready", idx, {31'b0, ext_ready}, {31'b0, v.exp_rdy});
        if (v.chk[2]) check("irq", idx, {31'b0, irq}, {31'b0, v.exp_irq});
        full_b  = (sb.size() == DEPTH);
        flush_b = v.en && v.we && (v.addr == 2'b10) && v.din[1];
        if (v.en && !v.we && v.addr == 2'b00) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_data", idx, dout, e);
            end else begin
                check("sb_empty_read", idx, dout, 32'h0);
            end
        end
        if (flush_b) sb.delete();
        if (v.ev && !full_b && !flush_b) sb.push_back(v.ed);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_push(input logic [31:0] x, input int idx);
        cyc(mk(0, 0, 2'b01, 0, 1, x, 3'b010, 0, 1, 0), idx);
    endtask

    initial begin
        rst = 1'b1; en = 0; we = 0; addr = 0; din = 0; ext_valid = 1'b1; ext_data = 32'hDEAD_0000;

        // Main table: R=read (check all), W/idle = check ready+irq only
        tbl.push_back(mk(1,0,2'b01,0,           0,0,            3'b111,32'h0000_0001,1,0)); // 0
        tbl.push_back(mk(0,0,2'b01,0,           1,32'hAAAA_0001,3'b110,0,1,0));
        tbl.push_back(mk(0,0,2'b01,0,           1,32'hBBBB_0002,3'b110,0,1,0));
        tbl.push_back(mk(1,0,2'b01,0,           0,0,            3'b111,32'h0000_0200,1,0));
        tbl.push_back(mk(1,0,2'b00,0,           0,0,            3'b111,32'hAAAA_0001,1,0));
        tbl.push_back(mk(1,0,2'b00,0,           0,0,            3'b111,32'hBBBB_0002,1,0)); // 5
        tbl.push_back(mk(1,0,2'b01,0,           0,0,            3'b111,32'h0000_0001,1,0));
        tbl.push_back(mk(1,0,2'b00,0,           0,0,            3'b111,32'h0000_0000,1,0));
        tbl.push_back(mk(1,1,2'b00,32'h1234_5678,0,0,           3'b110,0,1,0));
        tbl.push_back(mk(1,0,2'b01,0,           0,0,            3'b111,32'h0000_0001,1,0));
        tbl.push_back(mk(1,1,2'b11,32'hFFFF_FFFF,0,0,           3'b110,0,1,0));            // 10
        tbl.push_back(mk(1,1,2'b01,32'hFFFF_FFFF,0,0,           3'b110,0,1,0));
        tbl.push_back(mk(1,0,2'b01,0,           0,0,            3'b111,32'h0000_0001,1,0));
        tbl.push_back(mk(1,0,2'b11,0,           0,0,            3'b111,32'h0000_0000,1,0));
        tbl.push_back(mk(1,0,2'b10,0,           0,0,            3'b111,32'h0000_0000,1,0));
        tbl.push_back(mk(0,0,2'b01,0,           1,32'hC000_0000,3'b110,0,1,0));            // 15
        tbl.push_back(mk(0,0,2'b01,0,           1,32'hC000_0001,3'b110,0,1,0));
        tbl.push_back(mk(0,0,2'b01,0,           1,32'hC000_0002,3'b110,0,1,0));
        tbl.push_back(mk(0,0,2'b01,0,           1,32'hC000_0003,3'b110,0,1,0));
        tbl.push_back(mk(1,0,2'b01,0,           1,32'hC000_0004,3'b111,32'h0000_0402,0,0));
        tbl.push_back(mk(1,0,2'b01,0,           0,0,            3'b111,32'h0000_0406,0,0)); // 20
        tbl.push_back(mk(1,1,2'b10,32'h4,       0,0,            3'b110,0,0,0));
        tbl.push_back(mk(1,0,2'b01,0,           0,0,            3'b111,32'h0000_0402,0,0));
        tbl.push_back(mk(1,0,2'b00,0,           0,0,            3'b111,32'hC000_0000,0,0));
        tbl.push_back(mk(1,0,2'b00,0,           0,0,            3'b111,32'hC000_0001,1,0));
        tbl.push_back(mk(1,0,2'b00,0,           0,0,            3'b111,32'hC000_0002,1,0)); // 25
        tbl.push_back(mk(1,0,2'b00,0,           0,0,            3'b111,32'hC000_0003,1,0));
        tbl.push_back(mk(1,0,2'b01,0,           0,0,            3'b111,32'h0000_0001,1,0));
        tbl.push_back(mk(1,1,2'b10,32'h1,       0,0,            3'b110,0,1,0));
        tbl.push_back(mk(1,0,2'b10,0,           0,0,            3'b111,32'h0000_0001,1,0));
        tbl.push_back(mk(0,0,2'b01,0,           1,32'hD000_0000,3'b110,0,1,0));            // 30
        tbl.push_back(mk(0,0,2'b01,0,           0,0,            3'b110,0,1,1));
        tbl.push_back(mk(1,0,2'b00,0,           0,0,            3'b111,32'hD000_0000,1,1));
        tbl.push_back(mk(0,0,2'b01,0,           0,0,            3'b110,0,1,0));
        tbl.push_back(mk(0,0,2'b01,0,           1,32'hE000_0000,3'b110,0,1,0));
        tbl.push_back(mk(1,0,2'b00,0,           1,32'hE000_0001,3'b111,32'hE000_0000,1,1)); // 35
        tbl.push_back(mk(1,0,2'b01,0,           0,0,            3'b111,32'h0000_0108,1,1));
        tbl.push_back(mk(1,0,2'b00,0,           0,0,            3'b111,32'hE000_0001,1,1));
        tbl.push_back(mk(1,0,2'b01,0,           0,0,            3'b111,32'h0000_0001,1,0));
        tbl.push_back(mk(1,0,2'b00,0,           1,32'hF000_0000,3'b111,32'h0000_0000,1,0));
        tbl.push_back(mk(1,0,2'b01,0,           0,0,            3'b111,32'h0000_0108,1,1)); // 40
        tbl.push_back(mk(1,0,2'b00,0,           0,0,            3'b111,32'hF000_0000,1,1));
        tbl.push_back(mk(1,0,2'b01,0,           0,0,            3'b111,32'h0000_0001,1,0));

        // Reset with a producer already offering: no handshake may happen
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", 0, {31'b0, ext_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; ext_valid = 1'b0;

        for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], i);

        // Flush at count=3 with the producer offering a word (irq_en still 1)
        idle_push(32'h6000_0000, 100);
        idle_push(32'h6000_0001, 101);
        idle_push(32'h6000_0002, 102);
        cyc(mk(1,1,2'b10,32'h3,1,32'h6000_0003,3'b110,0,0,1), 103);
        cyc(mk(1,0,2'b01,0,    1,32'h6000_0003,3'b111,32'h0000_0001,1,0), 104);
        cyc(mk(1,0,2'b01,0,    0,0,            3'b111,32'h0000_0108,1,1), 105);
        cyc(mk(1,0,2'b00,0,    0,0,            3'b111,32'h6000_0003,1,1), 106);

        // Reset mid-operation at count=2 with a concurrent push offer
        idle_push(32'h7000_0000, 110);
        idle_push(32'h7000_0001, 111);
        cyc(mk(1,0,2'b01,0,0,0,3'b111,32'h0000_0208,1,1), 112);
        rst = 1'b1; en = 1'b1; we = 1'b0; addr = 2'b00; ext_valid = 1'b1; ext_data = 32'h7000_0002;
        @(negedge clk);
        check("ready_mid_reset", 113, {31'b0, ext_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        cyc(mk(1,0,2'b01,0,0,0,3'b111,32'h0000_0001,1,0), 114);
        cyc(mk(1,0,2'b10,0,0,0,3'b111,32'h0000_0000,1,0), 115);

        // Pointer wrap: overlapped push/pop pairs, order checked by the scoreboard
        idle_push(32'h5000_0000, 120);
        for (int i = 1; i <= 10; i++)
            cyc(mk(1,0,2'b00,0,1,32'h5000_0000 + 32'(i),3'b110,0,1,0), 120 + i);
        cyc(mk(1,0,2'b00,0,0,0,3'b110,0,1,0), 131);
        cyc(mk(1,0,2'b01,0,0,0,3'b111,32'h0000_0001,1,0), 132);
        check("sb_drained", 133, 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
